// File: rtl/encoder_fec_pkg.sv
// Shared types and constants for the FEC encoder datapath.
package encoder_fec_pkg;

    localparam int DATA_WIDTH = 8;
    typedef logic [DATA_WIDTH-1:0] message_data_t;

    localparam int                CONV_K                = 7;
    localparam logic [CONV_K-1:0] CONV_G0               = 7'o171;
    localparam logic [CONV_K-1:0] CONV_G1               = 7'o133;
    localparam int                CONV_SYMBOLS_PER_WORD = DATA_WIDTH + CONV_K - 1;

    typedef logic [1:0] code_symbol_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DATA,
        TAIL
    } conv_state_t;

endpackage

// File: rtl/conv_encoder_core.sv
// Combinational code-bit generator for a rate-1/2 convolutional encoder.
// The tap vector puts the current input bit at the MSB, followed by the
// history bits from most recent (sr[0]) to oldest (sr[K-2]).
module conv_encoder_core
    import encoder_fec_pkg::*;
#(
    parameter int           K  = CONV_K,
    parameter logic [K-1:0] G0 = CONV_G0,
    parameter logic [K-1:0] G1 = CONV_G1
) (
    input  logic         bit_in,
    input  logic [K-2:0] sr,
    output code_symbol_t code
);

    logic [K-1:0] taps;

    // Assemble the tap vector and reduce each generator mask to one parity bit.
    always_comb begin
        taps      = '0;
        taps[K-1] = bit_in;
        for (int i = 0; i < K - 1; i++) begin
            taps[K-2-i] = sr[i];
        end
        code = {^(taps & G0), ^(taps & G1)};
    end

endmodule

// File: rtl/fec_conv_encoder.sv
// Pops message words from the fifo and emits them MSB-first as rate-1/2,
// K=7 convolutional code symbols, terminating every word with K-1 zero
// tail bits so the encoder history returns to all-zero between words.
module fec_conv_encoder
    import encoder_fec_pkg::*;
#(
    parameter int                        DATA_WIDTH     = encoder_fec_pkg::DATA_WIDTH,
    parameter int                        CONSTRAINT_LEN = CONV_K,
    parameter logic [CONSTRAINT_LEN-1:0] G0             = CONV_G0,
    parameter logic [CONSTRAINT_LEN-1:0] G1             = CONV_G1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_valid,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output code_symbol_t          code_out,
    output logic                  code_valid,
    input  logic                  code_ready,
    output logic                  code_last,
    output logic                  busy
);

    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TAIL_W = (CONSTRAINT_LEN > 2) ? $clog2(CONSTRAINT_LEN - 1) : 1;

    conv_state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]        word_q, word_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [TAIL_W-1:0]            tail_q, tail_d;
    logic [CONSTRAINT_LEN-2:0]    sr_q, sr_d;
    logic                         rd_en_q, rd_en_d;
    logic                         bit_in;
    code_symbol_t                 core_code;

    conv_encoder_core #(
        .K  (CONSTRAINT_LEN),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .bit_in (bit_in),
        .sr     (sr_q),
        .code   (core_code)
    );

    // Control state, encoder history and counters; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tail_q  <= '0;
            sr_q    <= '0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tail_q  <= tail_d;
            sr_q    <= sr_d;
            rd_en_q <= rd_en_d;
        end
    end

    // Message word holding register; only meaningful while a word is in flight.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    // Next-state, counter and output decode; symbols only advance on a handshake.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        tail_d     = tail_q;
        sr_d       = sr_q;
        rd_en_d    = 1'b0;
        bit_in     = 1'b0;
        code_valid = 1'b0;
        code_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (fifo_rd_valid) begin
                    word_d  = fifo_data;
                    idx_d   = IDX_W'(DATA_WIDTH - 1);
                    state_d = DATA;
                end
            end
            DATA: begin
                code_valid = 1'b1;
                bit_in     = word_q[idx_q];
                if (code_ready) begin
                    sr_d = {sr_q[CONSTRAINT_LEN-3:0], bit_in};
                    if (idx_q == '0) begin
                        tail_d  = TAIL_W'(CONSTRAINT_LEN - 2);
                        state_d = TAIL;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            TAIL: begin
                code_valid = 1'b1;
                code_last  = (tail_q == '0);
                if (code_ready) begin
                    sr_d = {sr_q[CONSTRAINT_LEN-3:0], 1'b0};
                    if (tail_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        tail_d = tail_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_rd_en = rd_en_q;
    assign code_out   = code_valid ? core_code : 2'b00;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fec_conv_encoder.sv
// Directed bench for fec_conv_encoder: a behavioural 1-cycle-latency fifo
// feeds the encoder, a negedge monitor collects every accepted symbol.
module tb_fec_conv_encoder;
    import encoder_fec_pkg::*;

    localparam logic [6:0] REF_G0 = 7'o171;
    localparam logic [6:0] REF_G1 = 7'o133;
    localparam int         NSYM   = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic          fifo_rd_valid = 1'b0;
    message_data_t fifo_data = '0;
    code_symbol_t  code_out;
    logic          code_valid;
    logic          code_ready;
    logic          code_last;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    message_data_t fq[$];
    logic [2:0]    got[$];
    int            cyc = 0;
    int            rd_cnt, last_cnt, rd_cyc, first_valid_cyc, rd_while_empty;
    logic          valid_prev = 1'b0;

    logic [1:0] imp_tab  [NSYM] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11,
                                    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] zero_tab [NSYM] = '{default: 2'b00};
    logic [1:0] ff_head  [4]    = '{2'b11, 2'b01, 2'b10, 2'b01};

    fec_conv_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_valid (fifo_rd_valid),
        .fifo_data     (fifo_data),
        .code_out      (code_out),
        .code_valid    (code_valid),
        .code_ready    (code_ready),
        .code_last     (code_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural fifo with one cycle of read latency.
    always @(posedge clk) begin
        cyc++;
        fifo_rd_valid <= 1'b0;
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_data     <= fq.pop_front();
            fifo_rd_valid <= 1'b1;
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor: record symbols that will be accepted on the next rising edge.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt++;
            rd_cyc = cyc;
            if (fifo_empty) rd_while_empty++;
        end
        if (code_valid && !valid_prev && first_valid_cyc < 0) first_valid_cyc = cyc;
        valid_prev = code_valid;
        if (code_valid && code_ready) begin
            got.push_back({code_last, code_out});
            if (code_last) last_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic push_word(input message_data_t w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_mon();
        got.delete();
        rd_cnt          = 0;
        last_cnt        = 0;
        rd_cyc          = -1;
        first_valid_cyc = -1;
        rd_while_empty  = 0;
    endtask

    task automatic wait_syms(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (got.size() < n) check("symbol_timeout", got.size(), n);
    endtask

    function automatic logic [2:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 3'b111;
    endfunction

    // Reference convolution: code bit = XOR of generator taps against the input history.
    function automatic logic [1:0] model_sym(input message_data_t w, input int t);
        logic c0 = 1'b0;
        logic c1 = 1'b0;
        logic u;
        for (int j = 0; j < 7; j++) begin
            if (t - j >= 0) begin
                u  = (t - j < DATA_WIDTH) ? w[DATA_WIDTH-1-(t-j)] : 1'b0;
                c0 = c0 ^ (REF_G0[6-j] & u);
                c1 = c1 ^ (REF_G1[6-j] & u);
            end
        end
        return {c0, c1};
    endfunction

    task automatic cmp_table(input string tag, input logic [1:0] tab [NSYM]);
        for (int i = 0; i < NSYM; i++) begin
            check($sformatf("%s_sym%0d", tag, i), got_at(i), {(i == NSYM - 1), tab[i]});
        end
    endtask

    initial begin
        int n_rd, n_val, n_busy;
        message_data_t words [3];
        words = '{8'h80, 8'hFF, 8'h00};

        rst        = 1'b1;
        code_ready = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outputs", {fifo_rd_en, code_valid, code_out, code_last, busy}, 6'b0);
        check("reset_sr", dut.sr_q, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Impulse word.
        clear_mon();
        push_word(8'h80);
        wait_syms(NSYM, 200);
        cmp_table("impulse", imp_tab);
        check("impulse_rd_pulses", rd_cnt, 1);
        check("impulse_latency", first_valid_cyc - rd_cyc, 2);
        @(posedge clk); #1;
        check("impulse_busy_after", {busy, code_valid}, 2'b00);
        check("impulse_sr_after", dut.sr_q, 0);

        // All-zero word.
        repeat (2) @(posedge clk); #1;
        clear_mon();
        push_word(8'h00);
        wait_syms(NSYM, 200);
        cmp_table("zero", zero_tab);
        @(posedge clk); #1;
        check("zero_sr_after", dut.sr_q, 0);
        check("zero_busy_after", busy, 1'b0);

        // Backpressure stall at the 2nd symbol.
        repeat (2) @(posedge clk); #1;
        clear_mon();
        push_word(8'h80);
        wait_syms(1, 200);
        @(posedge clk); #1;
        code_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", s), {code_valid, code_last, code_out}, 4'b1010);
        end
        @(posedge clk); #1;
        code_ready = 1'b1;
        wait_syms(NSYM, 200);
        cmp_table("stall", imp_tab);
        check("stall_count", got.size(), NSYM);

        // Empty fifo: the encoder must stay quiet.
        repeat (2) @(posedge clk); #1;
        clear_mon();
        n_rd = 0; n_val = 0; n_busy = 0;
        repeat (50) begin
            @(negedge clk);
            if (fifo_rd_en) n_rd++;
            if (code_valid) n_val++;
            if (busy) n_busy++;
        end
        check("empty_rd_en", n_rd, 0);
        check("empty_valid", n_val, 0);
        check("empty_busy", n_busy, 0);

        // Back-to-back words against the reference model.
        clear_mon();
        for (int w = 0; w < 3; w++) push_word(words[w]);
        wait_syms(3 * NSYM, 600);
        for (int i = 0; i < 3 * NSYM; i++) begin
            check($sformatf("b2b_sym%0d", i), got_at(i),
                  {((i % NSYM) == NSYM - 1), model_sym(words[i / NSYM], i % NSYM)});
        end
        @(posedge clk); #1;
        check("b2b_total", got.size(), 3 * NSYM);
        check("b2b_rd_pulses", rd_cnt, 3);
        check("b2b_last_pulses", last_cnt, 3);
        check("b2b_rd_while_empty", rd_while_empty, 0);

        // Reset in the middle of an 8'hFF word.
        repeat (2) @(posedge clk); #1;
        clear_mon();
        push_word(8'hFF);
        wait_syms(4, 200);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ff_head%0d", i), got_at(i), {1'b0, ff_head[i]});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset_outputs", {fifo_rd_en, code_valid, code_out, code_last, busy}, 6'b0);
        check("midreset_sr", dut.sr_q, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        push_word(8'h80);
        wait_syms(NSYM, 200);
        cmp_table("after_reset", imp_tab);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fec_conv_encoder.md
Name: fec_conv_encoder

Overview:
- Stage directly downstream of the message fifo in the FEC encoder datapath.
- Pops one message_data_t word at a time from the fifo and shifts it MSB-first through a rate-1/2, K=7 convolutional encoder (generators 171/133 octal).
- Appends K-1 = 6 zero tail bits to terminate every word.
- Emits one 2-bit code symbol per accepted handshake to the modulator/serializer stage.

Parameters:
- DATA_WIDTH, default 8 (encoder_fec_pkg::DATA_WIDTH): message word width in bits.
- CONSTRAINT_LEN, default 7: encoder constraint length K; tail length is K-1.
- G0, default 7'o171: generator polynomial for code bit c0; MSB tap = current input bit.
- G1, default 7'o133: generator polynomial for code bit c1.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  fifo empty flag.
- fifo_rd_en  out  1  single-cycle read request to the fifo.
- fifo_rd_valid  in  1  fifo data_out is valid this cycle.
- fifo_data  in  DATA_WIDTH  fifo data_out, type message_data_t.
- code_out  out  2  code symbol {c0,c1}.
- code_valid  out  1  code_out is valid.
- code_ready  in  1  downstream accepts the symbol.
- code_last  out  1  marks the final tail symbol of a word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - Outputs: fifo_rd_en=0, code_out=0, code_valid=0, code_last=0, busy=0.
  - State: state=IDLE, shift register sr[K-2:0]=0, bit counter=0.
- Encoder core:
  - Tap vector v = {b, sr[0], ..., sr[K-2]}, where b is the current bit and sr[0] is the most recent previous bit.
  - c0 = ^(v & G0); c1 = ^(v & G1).
  - On each accepted symbol (code_valid & code_ready): sr <= {sr[K-3:0], b}.
- States:
  - IDLE:
    - If !fifo_empty: assert fifo_rd_en for exactly one cycle and go to WAIT.
    - Never assert fifo_rd_en while fifo_empty=1.
  - WAIT:
    - Hold until fifo_rd_valid=1, then latch fifo_data into the word register, set bit index to DATA_WIDTH-1, go to DATA.
    - Any read latency is tolerated.
  - DATA:
    - code_valid=1; b = word[idx]; code_out and code_valid are combinational from registered state.
    - On handshake: decrement idx. After bit 0 is accepted, go to TAIL with tail counter = K-2.
  - TAIL:
    - b=0; code_valid=1; code_last=1 when tail counter==0.
    - On handshake: decrement tail counter. After the final tail symbol is accepted: sr=0 (naturally, by shifting in zeros), go to IDLE.
- Backpressure: while code_valid=1 and code_ready=0, code_out, code_last, sr and counters stay frozen. The symbol is never dropped or duplicated.
- Timing:
  - Latency with a 1-cycle fifo: rd_en in cycle N, rd_valid in N+1, first code_valid in N+2.
  - Each word yields exactly DATA_WIDTH+K-1 symbols (14 at defaults).
  - Minimum 2 idle cycles between words (IDLE + WAIT).
- Boundaries:
  - fifo_rd_valid outside WAIT is ignored.
  - fifo going empty mid-word has no effect on the word in flight.
  - Reset mid-word aborts the word; the encoder restarts clean on the next fifo word.
  - code_ready may be high while code_valid=0; this is harmless.

Decomposition:
- encoder_fec_pkg gets:
  - CONV_K, CONV_G0, CONV_G1 and CONV_SYMBOLS_PER_WORD = DATA_WIDTH+CONV_K-1.
  - code_symbol_t (logic [1:0]).
  - conv_state_t enum {IDLE, WAIT, DATA, TAIL}.
  - Reuse the existing message_data_t and DATA_WIDTH.
- One natural sub-module, conv_encoder_core: purely combinational c0/c1 from (b, sr, G0, G1). The FSM and shift register stay in fec_conv_encoder.
- The top-level test instantiates fifo and fec_conv_encoder back to back.

Test Plan:
- Impulse: fifo holds 8'h80, code_ready=1.
  - Symbols in order: 11,10,11,11,00,01,11, then 00 x7.
  - code_last only on the 14th symbol; busy drops the next cycle.
- All-zero word 8'h00: 14 symbols all 2'b00, code_last on the 14th, sr=0 afterwards.
- Backpressure on word 8'h80: code_ready held low for 5 cycles at the 2nd symbol.
  - code_out stays 2'b10 throughout the stall.
  - The sequence then resumes identically to the impulse case.
- Empty fifo: fifo_empty=1 for 50 cycles → fifo_rd_en never asserts, code_valid=0, busy=0.
- Back-to-back: fill the fifo with 8'h80, 8'hFF, 8'h00 and compare against the reference model.
  - 42 symbols total; exactly 3 fifo_rd_en pulses; 3 code_last pulses.
  - The queue scoreboard matches every symbol.
- Reset mid-word: assert rst after the 4th symbol of 8'hFF.
  - All outputs go 0 at once.
  - After release, the next word 8'h80 produces the clean impulse sequence.
